// File: rtl/osd_ctm_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_ctm_sampler_if
// Description : Valid/ready sample bus between the CTM sampler (master) and
//               the CTM packetizer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface osd_ctm_sampler_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int TIME_WIDTH = 64
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [2:0]            sample_type;
    logic [ADDR_WIDTH-1:0] sample_pc;
    logic [ADDR_WIDTH-1:0] sample_npc;
    logic [1:0]            sample_prv;
    logic [TIME_WIDTH-1:0] sample_time;

    modport master (
        output sample_valid, sample_type, sample_pc, sample_npc,
               sample_prv, sample_time,
        input  sample_ready
    );

    modport slave (
        input  sample_valid, sample_type, sample_pc, sample_npc,
               sample_prv, sample_time,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/osd_ctm_sampler.sv
`default_nettype none
// ============================================================================
// Module      : osd_ctm_sampler
// Description : Filters the per-retire core trace bus down to control-flow
//               events, tags them with type/timestamp and buffers them in a
//               small FIFO drained over valid/ready. FIFO-full drops are
//               counted and reported in-band as an overflow marker (type 7).
//               Optional: OSD_CTM_SAMPLER_PRV_CHANGE_EN enables type-6
//               privilege-change events.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_ctm_sampler #(
    parameter int ADDR_WIDTH = 64,
    parameter int TIME_WIDTH = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  enable,
    input  wire logic                  trace_valid,
    input  wire logic [ADDR_WIDTH-1:0] trace_pc,
    input  wire logic [ADDR_WIDTH-1:0] trace_npc,
    input  wire logic                  trace_jal,
    input  wire logic                  trace_jalr,
    input  wire logic                  trace_branch,
    input  wire logic                  trace_br_taken,
    input  wire logic                  trace_trap,
    input  wire logic                  trace_xcpt,
    input  wire logic [1:0]            trace_prv,
    input  wire logic [TIME_WIDTH-1:0] trace_time,
    osd_ctm_sampler_if.master          smp,
    output logic                       overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_JAL  = 3'd1;
    localparam logic [2:0] TYPE_JALR = 3'd2;
    localparam logic [2:0] TYPE_BR   = 3'd3;
    localparam logic [2:0] TYPE_TRAP = 3'd4;
    localparam logic [2:0] TYPE_XCPT = 3'd5;
    localparam logic [2:0] TYPE_PRV  = 3'd6;
    localparam logic [2:0] TYPE_OVF  = 3'd7;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef struct packed {
        logic [2:0]            typ;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] npc;
        logic [1:0]            prv;
        logic [TIME_WIDTH-1:0] tim;
    } sample_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        OVF    = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [15:0]      drop_cnt, drop_nx, drop_inc;
    logic [1:0]       last_prv;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    sample_t          mem [FIFO_DEPTH];
    sample_t          head, push_data;
    logic [2:0]       ev_type;
    logic             ev, full, empty, push_req, push, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign ev    = (ev_type != TYPE_NONE);
    assign push  = push_req && !full;
    assign pop   = !empty && smp.sample_ready;
    assign drop_inc = (drop_cnt == DROP_MAX) ? drop_cnt : drop_cnt + 16'd1;

    // Classify the retiring instruction by fixed event priority.
    always_comb begin
        ev_type = TYPE_NONE;
        if (trace_valid && enable) begin
            if (trace_xcpt)                          ev_type = TYPE_XCPT;
            else if (trace_trap)                     ev_type = TYPE_TRAP;
            else if (trace_jalr)                     ev_type = TYPE_JALR;
            else if (trace_jal)                      ev_type = TYPE_JAL;
            else if (trace_branch && trace_br_taken) ev_type = TYPE_BR;
`ifdef OSD_CTM_SAMPLER_PRV_CHANGE_EN
            else if (trace_prv != last_prv)          ev_type = TYPE_PRV;
`endif
        end
    end

    // Overflow tracking: choose what to push and how the drop counter moves.
    always_comb begin
        state_nx      = state;
        drop_nx       = drop_cnt;
        push_req      = 1'b0;
        push_data.typ = ev_type;
        push_data.pc  = trace_pc;
        push_data.npc = trace_npc;
        push_data.prv = trace_prv;
        push_data.tim = trace_time;
        case (state)
            NORMAL: begin
                if (ev) begin
                    if (!full) begin
                        push_req = 1'b1;
                    end else begin
                        drop_nx  = 16'd1;
                        state_nx = OVF;
                    end
                end
            end
            OVF: begin
                if (!enable) begin
                    // Pending marker is abandoned along with the count.
                    drop_nx  = 16'd0;
                    state_nx = NORMAL;
                end else if (!full) begin
                    // A coincident event is dropped but folded into the marker.
                    push_req      = 1'b1;
                    push_data.typ = TYPE_OVF;
                    push_data.pc  = '0;
                    push_data.npc = {{(ADDR_WIDTH-16){1'b0}}, (ev ? drop_inc : drop_cnt)};
                    push_data.prv = last_prv;
                    drop_nx       = 16'd0;
                    state_nx      = NORMAL;
                end else if (ev) begin
                    drop_nx = drop_inc;
                end
            end
            default: begin
                state_nx = NORMAL;
                drop_nx  = 16'd0;
            end
        endcase
    end

    // State, drop counter, privilege tracking and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= NORMAL;
            drop_cnt <= 16'd0;
            last_prv <= 2'b11;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            drop_cnt <= drop_nx;
            if (trace_valid) begin
                last_prv <= trace_prv;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sample storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

    assign smp.sample_valid = !empty;
    assign smp.sample_type  = empty ? 3'd0 : head.typ;
    assign smp.sample_pc    = empty ? '0   : head.pc;
    assign smp.sample_npc   = empty ? '0   : head.npc;
    assign smp.sample_prv   = empty ? 2'd0 : head.prv;
    assign smp.sample_time  = empty ? '0   : head.tim;
    assign overflow         = (state == OVF);

endmodule
`default_nettype wire

// File: tb/tb_osd_ctm_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_ctm_sampler
// Description : Self-checking bench for osd_ctm_sampler: directed scenarios
//               plus a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_ctm_sampler;
    localparam int AW = 64;
    localparam int TW = 64;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable, trace_valid, trace_jal, trace_jalr, trace_branch;
    logic          trace_br_taken, trace_trap, trace_xcpt;
    logic [AW-1:0] trace_pc, trace_npc;
    logic [1:0]    trace_prv;
    logic [TW-1:0] trace_time;
    logic          overflow;
    int            checks = 0;
    int            errors = 0;

    osd_ctm_sampler_if #(.ADDR_WIDTH(AW), .TIME_WIDTH(TW)) smp_if ();

    osd_ctm_sampler #(.ADDR_WIDTH(AW), .TIME_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_npc(trace_npc), .trace_jal(trace_jal),
        .trace_jalr(trace_jalr), .trace_branch(trace_branch),
        .trace_br_taken(trace_br_taken), .trace_trap(trace_trap),
        .trace_xcpt(trace_xcpt), .trace_prv(trace_prv), .trace_time(trace_time),
        .smp(smp_if.master), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  t;
        logic [63:0] pc;
        logic [63:0] npc;
        logic [1:0]  prv;
        logic [63:0] tm;
    } smp_t;

    smp_t     mq[$];
    bit       m_ovf;
    int       m_cnt;
    logic [1:0] m_lastprv;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_cnt = 0;
        m_lastprv = 2'b11;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        smp_t it;
        logic [2:0] et;
        bit full, pop, do_push;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && smp_if.sample_ready;
        et = 3'd0;
        if (trace_valid && enable) begin
            if (trace_xcpt) et = 5;
            else if (trace_trap) et = 4;
            else if (trace_jalr) et = 2;
            else if (trace_jal) et = 1;
            else if (trace_branch && trace_br_taken) et = 3;
`ifdef OSD_CTM_SAMPLER_PRV_CHANGE_EN
            else if (trace_prv != m_lastprv) et = 6;
`endif
        end
        do_push = 0;
        it = '{t: et, pc: trace_pc, npc: trace_npc, prv: trace_prv, tm: trace_time};
        if (!m_ovf) begin
            if (et != 0) begin
                if (!full) do_push = 1;
                else begin m_ovf = 1; m_cnt = 1; end
            end
        end else if (!enable) begin
            m_ovf = 0; m_cnt = 0;
        end else if (!full) begin
            int n;
            n = (et != 0) ? m_cnt + 1 : m_cnt;
            if (n > 65535) n = 65535;
            it = '{t: 3'd7, pc: 64'd0, npc: 64'(n), prv: m_lastprv, tm: trace_time};
            do_push = 1;
            m_ovf = 0; m_cnt = 0;
        end else if (et != 0) begin
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
        if (pop) void'(mq.pop_front());
        if (do_push) mq.push_back(it);
        if (trace_valid) m_lastprv = trace_prv;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        trace_valid = 0; trace_jal = 0; trace_jalr = 0; trace_branch = 0;
        trace_br_taken = 0; trace_trap = 0; trace_xcpt = 0;
        trace_pc = '0; trace_npc = '0; trace_time = '0;
    endtask

    task automatic set_ev(input bit jal, input bit jalr, input bit br, input bit tk,
                          input bit trap, input bit xcpt,
                          input logic [63:0] pc, input logic [63:0] npc,
                          input logic [63:0] tm);
        trace_valid = 1; trace_jal = jal; trace_jalr = jalr; trace_branch = br;
        trace_br_taken = tk; trace_trap = trap; trace_xcpt = xcpt;
        trace_pc = pc; trace_npc = npc; trace_time = tm;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        enable = 1; trace_prv = 2'b11; smp_if.sample_ready = 0;
        model_reset();
        #1;
        checks++;
        if (smp_if.sample_valid !== 1'b0 || smp_if.sample_type !== 3'd0 ||
            smp_if.sample_pc !== '0 || smp_if.sample_npc !== '0 ||
            smp_if.sample_prv !== 2'd0 || smp_if.sample_time !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b t=%0d pc=%0h want all zero",
                     smp_if.sample_valid, smp_if.sample_type, smp_if.sample_pc);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_single_jal();
        smp_if.sample_ready = 1;
        set_ev(1, 0, 0, 0, 0, 0, 64'h1000, 64'h2000, 64'd5);
        cyc();
        clear_inputs();
        checks++;
        if (smp_if.sample_valid !== 1 || smp_if.sample_type !== 3'd1 ||
            smp_if.sample_pc !== 64'h1000 || smp_if.sample_npc !== 64'h2000 ||
            smp_if.sample_time !== 64'd5 || smp_if.sample_prv !== 2'd3) begin
            errors++;
            $display("FAIL single_jal: got v=%b t=%0d pc=%0h npc=%0h tm=%0d want 1/1/1000/2000/5",
                     smp_if.sample_valid, smp_if.sample_type, smp_if.sample_pc,
                     smp_if.sample_npc, smp_if.sample_time);
        end
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL single_jal_empty: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_priority();
        smp_if.sample_ready = 0;
        set_ev(0, 1, 1, 1, 0, 1, 64'h40, 64'h80, 64'd9);
        cyc();
        clear_inputs();
        checks++;
        if (smp_if.sample_valid !== 1 || smp_if.sample_type !== 3'd5) begin
            errors++;
            $display("FAIL priority_xcpt: got v=%b t=%0d want 1/5",
                     smp_if.sample_valid, smp_if.sample_type);
        end
        smp_if.sample_ready = 1;
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL priority_single: got valid %b want 0", smp_if.sample_valid);
        end
        set_ev(0, 0, 1, 0, 0, 0, 64'h50, 64'h54, 64'd10);
        cyc();
        clear_inputs();
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL branch_not_taken: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_overflow();
        smp_if.sample_ready = 0;
        for (int i = 0; i < 11; i++) begin
            set_ev(0, 0, 1, 1, 0, 0, 64'h100 + 64'(i), 64'h900, 64'(i));
            cyc();
            if (i == 7) begin
                checks++;
                if (overflow !== 0 || smp_if.sample_valid !== 1) begin
                    errors++;
                    $display("FAIL ovf_full_no_drop: got ovf=%b v=%b want 0/1",
                             overflow, smp_if.sample_valid);
                end
            end
        end
        clear_inputs();
        checks++;
        if (overflow !== 1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        smp_if.sample_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smp_if.sample_valid !== 1 || smp_if.sample_type !== 3'd3 ||
                smp_if.sample_pc !== 64'h100 + 64'(i)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got v=%b t=%0d pc=%0h want 1/3/%0h", i,
                         smp_if.sample_valid, smp_if.sample_type, smp_if.sample_pc,
                         64'h100 + 64'(i));
            end
            cyc();
        end
        checks++;
        if (smp_if.sample_valid !== 1 || smp_if.sample_type !== 3'd7 ||
            smp_if.sample_npc !== 64'd3 || smp_if.sample_pc !== 64'd0 ||
            smp_if.sample_prv !== 2'd3 || overflow !== 0) begin
            errors++;
            $display("FAIL ovf_marker: got v=%b t=%0d pc=%0h npc=%0d ovf=%b want 1/7/0/3/0",
                     smp_if.sample_valid, smp_if.sample_type, smp_if.sample_pc,
                     smp_if.sample_npc, overflow);
        end
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL ovf_after_marker: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_ovf_event_marker();
        smp_if.sample_ready = 0;
        for (int i = 0; i < 10; i++) begin
            set_ev(0, 0, 1, 1, 0, 0, 64'h200 + 64'(i), 64'h0, 64'(i));
            cyc();
        end
        clear_inputs();
        smp_if.sample_ready = 1;
        cyc();
        smp_if.sample_ready = 0;
        set_ev(1, 0, 0, 0, 0, 0, 64'h999, 64'h777, 64'd42);
        cyc();
        clear_inputs();
        checks++;
        if (overflow !== 0) begin
            errors++;
            $display("FAIL ovfev_state: got ovf %b want 0", overflow);
        end
        smp_if.sample_ready = 1;
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (smp_if.sample_type !== 3'd3 || smp_if.sample_pc !== 64'h200 + 64'(i)) begin
                errors++;
                $display("FAIL ovfev_drain[%0d]: got t=%0d pc=%0h want 3/%0h", i,
                         smp_if.sample_type, smp_if.sample_pc, 64'h200 + 64'(i));
            end
            cyc();
        end
        checks++;
        if (smp_if.sample_type !== 3'd7 || smp_if.sample_npc !== 64'd3 ||
            smp_if.sample_time !== 64'd42) begin
            errors++;
            $display("FAIL ovfev_marker: got t=%0d npc=%0d tm=%0d want 7/3/42",
                     smp_if.sample_type, smp_if.sample_npc, smp_if.sample_time);
        end
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL ovfev_jal_dropped: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_enable_drop();
        smp_if.sample_ready = 0;
        for (int i = 0; i < 9; i++) begin
            set_ev(0, 0, 1, 1, 0, 0, 64'h300 + 64'(i), 64'h0, 64'(i));
            cyc();
        end
        clear_inputs();
        enable = 0;
        cyc();
        checks++;
        if (overflow !== 0) begin
            errors++;
            $display("FAIL endrop_state: got ovf %b want 0", overflow);
        end
        enable = 1;
        smp_if.sample_ready = 1;
        for (int i = 0; i < 8; i++) cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL endrop_no_marker: got valid %b t=%0d want 0",
                     smp_if.sample_valid, smp_if.sample_type);
        end
    endtask

    task automatic test_prv_change();
        smp_if.sample_ready = 0;
        clear_inputs();
        trace_valid = 1; trace_prv = 2'd0; trace_pc = 64'h600; trace_time = 64'd77;
        cyc();
        clear_inputs();
        checks++;
`ifdef OSD_CTM_SAMPLER_PRV_CHANGE_EN
        if (smp_if.sample_valid !== 1 || smp_if.sample_type !== 3'd6 ||
            smp_if.sample_prv !== 2'd0) begin
            errors++;
            $display("FAIL prv_change: got v=%b t=%0d prv=%0d want 1/6/0",
                     smp_if.sample_valid, smp_if.sample_type, smp_if.sample_prv);
        end
`else
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL prv_change_off: got valid %b want 0", smp_if.sample_valid);
        end
`endif
        smp_if.sample_ready = 1;
        cyc();
        // Return to machine mode with capture disabled: tracks prv, no event.
        enable = 0; trace_valid = 1; trace_prv = 2'd3;
        cyc();
        clear_inputs();
        enable = 1;
        cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL prv_disabled: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_reset_midstream();
        smp_if.sample_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_ev(1, 0, 0, 0, 0, 0, 64'h700 + 64'(i), 64'h0, 64'(i));
            cyc();
        end
        clear_inputs();
        checks++;
        if (smp_if.sample_valid !== 1) begin
            errors++;
            $display("FAIL midrst_pre: got valid %b want 1", smp_if.sample_valid);
        end
        #2;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (smp_if.sample_valid !== 0 || smp_if.sample_type !== 0 ||
            smp_if.sample_pc !== '0 || overflow !== 0) begin
            errors++;
            $display("FAIL midrst_async: got v=%b t=%0d pc=%0h want 0/0/0",
                     smp_if.sample_valid, smp_if.sample_type, smp_if.sample_pc);
        end
        @(posedge clk); #1;
        rst = 1;
        smp_if.sample_ready = 1;
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (smp_if.sample_valid !== 0) begin
            errors++;
            $display("FAIL midrst_stale: got valid %b want 0", smp_if.sample_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            clear_inputs();
            enable = ($urandom_range(0, 99) < 95);
            smp_if.sample_ready = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 99) < 70) begin
                trace_valid = 1;
                case ($urandom_range(0, 7))
                    0: trace_jal = 1;
                    1: trace_jalr = 1;
                    2: begin trace_branch = 1; trace_br_taken = $urandom_range(0, 1); end
                    3: trace_trap = 1;
                    4: trace_xcpt = 1;
                    5: begin trace_jal = 1; trace_branch = 1; trace_br_taken = 1; end
                    default: ;
                endcase
                if ($urandom_range(0, 99) < 15) trace_prv = 2'($urandom_range(0, 3));
            end
            trace_pc   = {$urandom, $urandom};
            trace_npc  = {$urandom, $urandom};
            trace_time = 64'(n) * 64'd3;
            cyc();
            checks++;
            if (smp_if.sample_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b want %b", n,
                         smp_if.sample_valid, mq.size() != 0);
            end else if (mq.size() != 0) begin
                checks++;
                if (smp_if.sample_type !== mq[0].t || smp_if.sample_pc !== mq[0].pc ||
                    smp_if.sample_npc !== mq[0].npc || smp_if.sample_prv !== mq[0].prv ||
                    smp_if.sample_time !== mq[0].tm) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got t=%0d pc=%0h npc=%0h prv=%0d tm=%0d want t=%0d pc=%0h npc=%0h prv=%0d tm=%0d",
                             n, smp_if.sample_type, smp_if.sample_pc, smp_if.sample_npc,
                             smp_if.sample_prv, smp_if.sample_time, mq[0].t, mq[0].pc,
                             mq[0].npc, mq[0].prv, mq[0].tm);
                end
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_ovf@%0d: got %b want %b", n, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_jal();
        test_priority();
        test_overflow();
        test_ovf_event_marker();
        test_enable_drop();
        test_prv_change();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/osd_ctm_sampler.md
Name: osd_ctm_sampler

Overview:
Front-end stage directly upstream of the core trace module (CTM) packetizer. Watches the per-retire core trace bus and keeps only control-flow events: jumps, taken branches, traps, exceptions and privilege changes. Each kept event is tagged with a type and timestamp and buffered in a small FIFO. The packetizer drains the FIFO over a valid/ready interface. Drops caused by a full FIFO are counted and reported in-band as an overflow marker sample.

Parameters:
ADDR_WIDTH, 64, width of pc/npc
TIME_WIDTH, 64, width of timestamp
FIFO_DEPTH, 8, sample buffer entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
enable  in  1  capture enable from CTM config register
trace_valid  in  1  one instruction retired this cycle
trace_pc  in  ADDR_WIDTH  retired pc
trace_npc  in  ADDR_WIDTH  next pc
trace_jal  in  1  instruction is jal
trace_jalr  in  1  instruction is jalr
trace_branch  in  1  instruction is conditional branch
trace_br_taken  in  1  branch taken
trace_trap  in  1  trap taken
trace_xcpt  in  1  exception raised
trace_prv  in  2  current privilege level
trace_time  in  TIME_WIDTH  timestamp
sample_valid  out  1  head sample available
sample_ready  in  1  packetizer accepts head sample
sample_type  out  3  event type
sample_pc  out  ADDR_WIDTH  event pc (0 for overflow marker)
sample_npc  out  ADDR_WIDTH  event npc; overflow marker: drop count zero-extended
sample_prv  out  2  privilege at event
sample_time  out  TIME_WIDTH  event timestamp
overflow  out  1  high while in OVF state

Behaviour:
- Reset (rst=0, async): FIFO empty, sample_valid=0, all sample_* outputs=0, overflow=0, drop counter=0, last_prv=2'b11, state=NORMAL.
- Event classification is combinational, and only when trace_valid=1 and enable=1. Priority is xcpt(5) > trap(4) > jalr(2) > jal(1) > branch taken (trace_branch and trace_br_taken, 3) > privilege change (trace_prv != last_prv, 6).
- Not-taken branches and other instructions produce no event.
- Type 7 = OVERFLOW marker. Type 0 is never emitted.
- last_prv is updated on every trace_valid=1 cycle, regardless of enable.
- Latency: a qualifying event in cycle N is written at the edge ending N. sample_valid is high in N+1 if the FIFO was empty.
- FIFO: head is presented directly on sample_*. A pop occurs when sample_valid && sample_ready.
- Full is the registered count == FIFO_DEPTH. A push into a full FIFO is rejected even if a pop occurs that same cycle (no push-through).
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Outputs are held stable while sample_valid=1 and sample_ready=0.
- State machine:
  - NORMAL: event with FIFO not full -> push. Event with FIFO full -> drop, counter=1, go to OVF.
  - OVF (overflow=1), FIFO still full: each event increments the counter, saturating at 2^16-1.
  - OVF, FIFO not full: push a marker {type=7, pc=0, npc=count, prv=last_prv, time=trace_time}. If an event occurs in this same cycle, it is dropped and included in the marker as count+1, saturating. Then clear the counter and go to NORMAL.
- enable falling to 0: capture stops. The FIFO continues to drain. If in OVF, the state, counter and pending marker are discarded and the state returns to NORMAL.
- Reset asserted mid-operation discards all FIFO contents immediately.

Optional Feature:
Macro OSD_CTM_SAMPLER_PRV_CHANGE_EN.
- Defined: privilege-change events (type 6) are generated as above.
- Undefined: type 6 is never generated. The last_prv register still exists, because the overflow marker uses it. An instruction whose only qualifying attribute is a privilege change produces no event.

Test Plan:
- Reset, then a single jal (pc=0x1000, npc=0x2000, time=5, prv=3) with sample_ready=1 -> next cycle sample_valid=1, type=1, pc=0x1000, npc=0x2000, time=5. Popped; FIFO empty afterwards.
- One cycle with trace_xcpt=1, trace_jalr=1, trace_branch=1, trace_br_taken=1 -> exactly one sample, type=5. Branch with br_taken=0 -> no sample.
- sample_ready=0, 8 taken branches fill the FIFO, then 3 more -> overflow=1. Release ready: 8 type-3 samples, then marker type=7, npc=3. overflow returns to 0.
- FIFO full and in OVF; on the first not-full cycle a jal arrives -> marker npc=count+1. The jal is not buffered; state returns to NORMAL.
- Privilege change 3 -> 0 on a plain instruction -> type 6, prv=0 with the macro defined; no sample without it.
- Assert rst mid-stream with 5 samples buffered -> sample_valid=0 immediately (async). No stale samples after reset release.
